pipelined_wallace_tree: RTL and testbench
=========================================

# pipelined_wallace_tree

Registered, flow-controlled successor to the combinational 13-input Wallace tree in the MAC multiplier path. It reduces 13 Booth partial products to a sum/carry pair for the final adder. It adds a valid/ready handshake with backpressure, a synchronous flush, and an optional mid-tree register stage. It sits between the Booth partial-product generator and the final carry-propagate adder, and lets the MAC run at a higher clock rate.

## Interface
- PARM_MANT, 23, mantissa width; datapath width W = 2*PARM_MANT+3 (49 at default)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous kill of all in-flight entries
- valid_i  in  1  partial-product set present
- ready_o  out  1  block accepts input this cycle
- pp_00_i .. pp_11_i  in  W each  partial products 0–11
- pp_12_i  in  W-1  partial product 12, zero-extended to W internally
- valid_o  out  1  result present
- ready_i  in  1  downstream accepts result
- wallace_sum_o  out  W  sum vector
- wallace_carry_o  out  W  carry vector, already aligned; the final adder uses sum+carry
- suppression_sign_extension_o  out  1  sign-extension suppression flag for the result

## Operation
- Carry vectors from every compressor are shifted left by 1 before reuse, and the MSB is discarded. All arithmetic is modulo 2^W.
- Tree structure:
  - L1: four 3:2 compressors on pp {00,01,02}, {03,04,05}, {06,07,08}, {09,10,11} → s0..s3, c0..c3.
  - L2: 3:2 on (s0, c0<<1, s1) → s4/c4; 3:2 on (c1<<1, s2, c2<<1) → s5/c5; 3:2 on (s3, c3<<1, pp_12) → s6/c6.
  - L3: 3:2 on (s4, c4<<1, s5) → s7/c7; 3:2 on (c5<<1, s6, c6<<1) → s8/c8.
  - L4: 4:2 compressor on (s7, c7<<1, s8, c8<<1) → sum, carry, hidden carry MSB h.
- suppression flag = OR of the unshifted carry MSBs of c3..c8, OR h.
- Invariant: (wallace_sum_o + wallace_carry_o) mod 2^W == (Σ pp_00..pp_11 + pp_12) mod 2^W.
- Each stage has one valid bit. A stage's data register loads only when that stage accepts new data; otherwise it holds.
- A stage accepts when its valid bit is 0 or the next stage accepts. The output stage accepts when valid_o=0 or ready_i=1.
- ready_o = acceptance condition of the first stage. It is combinational from ready_i through the valid bits; no skid buffer.
- Input transfer occurs when valid_i & ready_o. Output transfer occurs when valid_o & ready_i.
- flush_i=1: all valid bits clear on the next edge. An input offered in the same cycle is dropped, and flush has priority over everything else. Data registers are not cleared.
- While valid_o=1 and ready_i=0, wallace_sum_o, wallace_carry_o and suppression_sign_extension_o are stable.

## Timing
- Reset: all valid bits 0, so valid_o=0. All data registers 0, so wallace_sum_o=0, wallace_carry_o=0, suppression_sign_extension_o=0. ready_o=1 once reset deasserts.
- rst_i asserted mid-operation: in-flight data is lost immediately (asynchronous); outputs take the reset values above.
- Latency is 2 cycles with the macro defined and 1 cycle without, measured from the input transfer edge to valid_o.
- Throughput is 1 result per cycle when ready_i is held at 1.
- Full pipeline with ready_i=0: ready_o=0.
- A simultaneous output transfer and input transfer in the same cycle is legal. Occupancy is unchanged and no bubble is inserted.
- valid_o is held until the transfer completes. Results are never dropped except by flush or reset.

## Configuration
- WALLACE_MID_PIPE_EN defined:
  - Register stage after L2 captures s4, c4, s5, c5, s6, c6 plus a partial flag (OR of carry MSBs c3..c6).
  - The output stage computes L3/L4 and ORs in c7, c8 and h.
  - Depth is 2 and latency is 2.
- Undefined:
  - The whole tree is combinational into a single output register stage.
  - Depth is 1 and latency is 1.
  - Results are bit-identical to the defined case.

## Test plan
- Basic sum: pp_00=1, pp_01=2, all others 0, ready_i=1. valid_o rises after the configured latency; sum+carry mod 2^49 = 3; flag=0.
- Wrap-around: all pp_00..pp_11 = 2^49-1 and pp_12 = 2^48-1. Sum+carry mod 2^49 = (12·(2^49-1) + 2^48-1) mod 2^49; flag=1 (carry MSB of c3 set).
- Backpressure: issue 3 back-to-back inputs with ready_i=0.
  - With the macro, ready_o drops after 2 accepted; without it, after 1.
  - Outputs stay stable for 4 cycles.
  - On raising ready_i, results drain in order with no loss or duplicate.
- Streaming: 100 random sets with ready_i=1. One result per cycle, each matching the reference modulo sum; ready_o stays 1.
- Flush: 2 entries in flight, plus flush_i=1 together with valid_i=1. Next cycle valid_o=0, the offered input is discarded, and the next accepted input yields the correct result.
- Reset mid-stream: assert rst_i asynchronously between clock edges with valid_o=1. valid_o, wallace_sum_o and wallace_carry_o go to 0 immediately; ready_o=1 after deassertion.

Source files
------------

// File: rtl/pipelined_wallace_tree.sv
// pipelined_wallace_tree
// Registered, flow-controlled 13-input Wallace tree. It reduces 13 Booth partial
// products to a sum/carry pair for the final carry-propagate adder.
// Optional macro WALLACE_MID_PIPE_EN inserts a register stage after L2. Depth is 2
// with the macro defined and 1 without it; results are bit-identical either way.
module pipelined_wallace_tree #(
    parameter  int PARM_MANT = 23,
    localparam int W         = 2*PARM_MANT + 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] pp_00_i,
    input  logic [W-1:0] pp_01_i,
    input  logic [W-1:0] pp_02_i,
    input  logic [W-1:0] pp_03_i,
    input  logic [W-1:0] pp_04_i,
    input  logic [W-1:0] pp_05_i,
    input  logic [W-1:0] pp_06_i,
    input  logic [W-1:0] pp_07_i,
    input  logic [W-1:0] pp_08_i,
    input  logic [W-1:0] pp_09_i,
    input  logic [W-1:0] pp_10_i,
    input  logic [W-1:0] pp_11_i,
    input  logic [W-2:0] pp_12_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] wallace_sum_o,
    output logic [W-1:0] wallace_carry_o,
    output logic         suppression_sign_extension_o
);

    // 3:2 compressor sum and raw (unshifted) carry
    function automatic logic [W-1:0] csa_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [W-1:0] csa_cy(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Carry weight alignment: shift left by one, MSB falls off (modulo 2^W)
    function automatic logic [W-1:0] align(input logic [W-1:0] cy);
        return {cy[W-2:0], 1'b0};
    endfunction

    logic [W-1:0] pp12_ext;
    logic [W-1:0] s0, s1, s2, s3, c0, c1, c2, c3;
    logic [W-1:0] s4, s5, s6, c4, c5, c6;
    logic         flag_l2;

    assign pp12_ext = {1'b0, pp_12_i};

    // L1: four 3:2 compressors over pp 0..11
    assign s0 = csa_sum(pp_00_i, pp_01_i, pp_02_i);
    assign c0 = csa_cy (pp_00_i, pp_01_i, pp_02_i);
    assign s1 = csa_sum(pp_03_i, pp_04_i, pp_05_i);
    assign c1 = csa_cy (pp_03_i, pp_04_i, pp_05_i);
    assign s2 = csa_sum(pp_06_i, pp_07_i, pp_08_i);
    assign c2 = csa_cy (pp_06_i, pp_07_i, pp_08_i);
    assign s3 = csa_sum(pp_09_i, pp_10_i, pp_11_i);
    assign c3 = csa_cy (pp_09_i, pp_10_i, pp_11_i);

    // L2: three 3:2 compressors, pp_12 enters here
    assign s4 = csa_sum(s0, align(c0), s1);
    assign c4 = csa_cy (s0, align(c0), s1);
    assign s5 = csa_sum(align(c1), s2, align(c2));
    assign c5 = csa_cy (align(c1), s2, align(c2));
    assign s6 = csa_sum(s3, align(c3), pp12_ext);
    assign c6 = csa_cy (s3, align(c3), pp12_ext);

    assign flag_l2 = c3[W-1] | c4[W-1] | c5[W-1] | c6[W-1];

    // L3 operand sources: registered mid-tree values or the live L2 outputs
    logic [W-1:0] l3_s4, l3_s5, l3_s6, l3_c4, l3_c5, l3_c6;
    logic         l3_flag;
    logic         in_vld_p1;
    logic         acc_p1;
    logic         vld_p1;

    assign acc_p1 = ~vld_p1 | ready_i;

`ifdef WALLACE_MID_PIPE_EN
    logic         vld_p0;
    logic         acc_p0;
    logic [W-1:0] s4_p0, s5_p0, s6_p0, c4_p0, c5_p0, c6_p0;
    logic         flag_p0;

    assign acc_p0    = ~vld_p0 | acc_p1;
    assign ready_o   = acc_p0;
    assign in_vld_p1 = vld_p0;

    // Mid-tree stage valid bit: flush wins, otherwise advance when accepting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        vld_p0 <= 1'b0;
        else if (flush_i) vld_p0 <= 1'b0;
        else if (acc_p0)  vld_p0 <= valid_i;
    end

    // Mid-tree data capture of the L2 results on input transfer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s4_p0 <= '0; s5_p0 <= '0; s6_p0 <= '0;
            c4_p0 <= '0; c5_p0 <= '0; c6_p0 <= '0;
            flag_p0 <= 1'b0;
        end else if (acc_p0 && valid_i) begin
            s4_p0 <= s4; s5_p0 <= s5; s6_p0 <= s6;
            c4_p0 <= c4; c5_p0 <= c5; c6_p0 <= c6;
            flag_p0 <= flag_l2;
        end
    end

    // ---- stage boundary p0 -> p1 ----
    assign l3_s4 = s4_p0; assign l3_s5 = s5_p0; assign l3_s6 = s6_p0;
    assign l3_c4 = c4_p0; assign l3_c5 = c5_p0; assign l3_c6 = c6_p0;
    assign l3_flag = flag_p0;
`else
    assign ready_o   = acc_p1;
    assign in_vld_p1 = valid_i;

    assign l3_s4 = s4; assign l3_s5 = s5; assign l3_s6 = s6;
    assign l3_c4 = c4; assign l3_c5 = c5; assign l3_c6 = c6;
    assign l3_flag = flag_l2;
`endif

    logic [W-1:0] s7, s8, c7, c8;
    logic [W-1:0] t_s, t_c, fin_sum, fin_cy;
    logic         h_bit, flag_fin;

    // L3: two 3:2 compressors
    assign s7 = csa_sum(l3_s4, align(l3_c4), l3_s5);
    assign c7 = csa_cy (l3_s4, align(l3_c4), l3_s5);
    assign s8 = csa_sum(align(l3_c5), l3_s6, align(l3_c6));
    assign c8 = csa_cy (align(l3_c5), l3_s6, align(l3_c6));

    // L4: 4:2 compressor built from two chained 3:2 cells; h collects lost carry MSBs
    assign t_s     = csa_sum(s7, align(c7), s8);
    assign t_c     = csa_cy (s7, align(c7), s8);
    assign fin_sum = csa_sum(t_s, align(c8), align(t_c));
    assign fin_cy  = csa_cy (t_s, align(c8), align(t_c));
    assign h_bit   = t_c[W-1] | fin_cy[W-1];

    assign flag_fin = l3_flag | c7[W-1] | c8[W-1] | h_bit;

    logic [W-1:0] sum_p1, carry_p1;
    logic         flag_p1;

    // Output stage valid bit: flush wins, otherwise advance when accepting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        vld_p1 <= 1'b0;
        else if (flush_i) vld_p1 <= 1'b0;
        else if (acc_p1)  vld_p1 <= in_vld_p1;
    end

    // Output data capture; holds while the result waits for ready_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_p1   <= '0;
            carry_p1 <= '0;
            flag_p1  <= 1'b0;
        end else if (acc_p1 && in_vld_p1) begin
            sum_p1   <= fin_sum;
            carry_p1 <= align(fin_cy);
            flag_p1  <= flag_fin;
        end
    end

    assign valid_o                      = vld_p1;
    assign wallace_sum_o                = sum_p1;
    assign wallace_carry_o              = carry_p1;
    assign suppression_sign_extension_o = flag_p1;

endmodule

// File: tb/tb_pipelined_wallace_tree.sv
// tb_pipelined_wallace_tree
// Randomized bench for pipelined_wallace_tree. Expected results come from a plain
// modular sum of the partial products. Honors WALLACE_MID_PIPE_EN for depth.
module tb_pipelined_wallace_tree;
    localparam int PARM_MANT = 23;
    localparam int W = 2*PARM_MANT + 3;
`ifdef WALLACE_MID_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_i, flush_i, valid_i, ready_i;
    logic [W-1:0] ppv [0:12];
    logic         ready_o, valid_o, flag_o;
    logic [W-1:0] sum_o, carry_o;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    pipelined_wallace_tree #(.PARM_MANT(PARM_MANT)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .pp_00_i(ppv[0]), .pp_01_i(ppv[1]), .pp_02_i(ppv[2]), .pp_03_i(ppv[3]),
        .pp_04_i(ppv[4]), .pp_05_i(ppv[5]), .pp_06_i(ppv[6]), .pp_07_i(ppv[7]),
        .pp_08_i(ppv[8]), .pp_09_i(ppv[9]), .pp_10_i(ppv[10]), .pp_11_i(ppv[11]),
        .pp_12_i(ppv[12][W-2:0]),
        .valid_o(valid_o), .ready_i(ready_i),
        .wallace_sum_o(sum_o), .wallace_carry_o(carry_o),
        .suppression_sign_extension_o(flag_o)
    );

    // Reference: plain sum of all partial products modulo 2^W
    function automatic logic [W-1:0] model_sum();
        logic [W+3:0] acc;
        acc = '0;
        for (int i = 0; i < 12; i++) acc = acc + {4'b0, ppv[i]};
        acc = acc + {5'b0, ppv[12][W-2:0]};
        return acc[W-1:0];
    endfunction

    function automatic logic [W-1:0] obs_sum();
        return sum_o + carry_o;
    endfunction

    task automatic randomize_pp();
        logic [63:0] t;
        for (int i = 0; i < 13; i++) begin
            t = {$urandom, $urandom};
            ppv[i] = t[W-1:0];
        end
        ppv[12][W-1] = 1'b0;
    endtask

    task automatic clear_pp();
        for (int i = 0; i < 13; i++) ppv[i] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        clear_pp();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", valid_o); end
        checks++; if (sum_o !== '0) begin failures++; $display("FAIL reset_sum got=%0h want=0", sum_o); end
        checks++; if (carry_o !== '0) begin failures++; $display("FAIL reset_carry got=%0h want=0", carry_o); end
        checks++; if (flag_o !== 1'b0) begin failures++; $display("FAIL reset_flag got=%0b want=0", flag_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b want=1", ready_o); end
    endtask

    task automatic test_basic();
        step();
        clear_pp();
        ppv[0] = 1; ppv[1] = 2;
        valid_i = 1'b1; ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        for (int n = 1; n < LAT; n++) begin
            checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL basic_early_valid cycle=%0d got=%0b want=0", n, valid_o); end
            step();
        end
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b want=1", valid_o); end
        checks++; if (obs_sum() !== 49'd3) begin failures++; $display("FAIL basic_sum got=%0h want=3", obs_sum()); end
        checks++; if (flag_o !== 1'b0) begin failures++; $display("FAIL basic_flag got=%0b want=0", flag_o); end
        step();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0b want=0", valid_o); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] e;
        int n;
        for (int i = 0; i < 12; i++) ppv[i] = '1;
        ppv[12] = {1'b0, {(W-1){1'b1}}};
        e = model_sum();
        valid_i = 1'b1; ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 10) begin step(); n++; end
        checks++; if (n !== LAT-1) begin failures++; $display("FAIL wrap_latency got=%0d want=%0d", n+1, LAT); end
        checks++; if (obs_sum() !== e) begin failures++; $display("FAIL wrap_sum got=%0h want=%0h", obs_sum(), e); end
        checks++; if (flag_o !== 1'b1) begin failures++; $display("FAIL wrap_flag got=%0b want=1", flag_o); end
        step();
    endtask

    task automatic test_back_to_back();
        int got, gaps, drops;
        logic [W-1:0] e;
        got = 0; gaps = 0; drops = 0;
        exp_q.delete();
        ready_i = 1'b1;
        for (int t = 0; t < 100 + LAT + 2; t++) begin
            if (t < 100) begin
                randomize_pp(); valid_i = 1'b1;
                exp_q.push_back(model_sum());
            end else valid_i = 1'b0;
            #1;
            if (t < 100 && ready_o !== 1'b1) drops++;
            if (valid_o === 1'b1) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL stream_extra cycle=%0d got=%0h want=none", t, obs_sum());
                end else begin
                    e = exp_q.pop_front();
                    if (obs_sum() !== e) begin failures++; $display("FAIL stream_data idx=%0d got=%0h want=%0h", got-1, obs_sum(), e); end
                end
            end else if (t >= LAT && t < 100 + LAT) gaps++;
            step();
        end
        checks++; if (got !== 100) begin failures++; $display("FAIL stream_count got=%0d want=100", got); end
        checks++; if (gaps !== 0) begin failures++; $display("FAIL stream_gaps got=%0d want=0", gaps); end
        checks++; if (drops !== 0) begin failures++; $display("FAIL stream_ready_drops got=%0d want=0", drops); end
    endtask

    task automatic test_backpressure();
        int accepted, got;
        logic [W-1:0] snap_s, snap_c, e;
        logic snap_f;
        accepted = 0; got = 0;
        exp_q.delete();
        ready_i = 1'b0;
        for (int t = 0; t < 4; t++) begin
            randomize_pp(); valid_i = 1'b1;
            #1;
            if (ready_o === 1'b1) begin exp_q.push_back(model_sum()); accepted++; end
            step();
        end
        checks++; if (accepted !== LAT) begin failures++; $display("FAIL bp_accepted got=%0d want=%0d", accepted, LAT); end
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready got=%0b want=0", ready_o); end
        snap_s = sum_o; snap_c = carry_o; snap_f = flag_o;
        for (int t = 0; t < 4; t++) begin
            randomize_pp();
            step();
            checks++;
            if (valid_o !== 1'b1 || sum_o !== snap_s || carry_o !== snap_c || flag_o !== snap_f || ready_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got=%0b/%0h/%0h/%0b/%0b want=1/%0h/%0h/%0b/0",
                         t, valid_o, sum_o, carry_o, flag_o, ready_o, snap_s, snap_c, snap_f);
            end
        end
        ready_i = 1'b1;
        for (int t = 0; t < 20 && got < 3; t++) begin
            if (accepted < 3) begin randomize_pp(); valid_i = 1'b1; end
            else valid_i = 1'b0;
            #1;
            if (valid_i && ready_o === 1'b1) begin exp_q.push_back(model_sum()); accepted++; end
            if (valid_o === 1'b1) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL bp_extra got=%0h want=none", obs_sum());
                end else begin
                    e = exp_q.pop_front();
                    if (obs_sum() !== e) begin failures++; $display("FAIL bp_drain idx=%0d got=%0h want=%0h", got-1, obs_sum(), e); end
                end
            end
            step();
        end
        valid_i = 1'b0;
        checks++; if (got !== 3) begin failures++; $display("FAIL bp_count got=%0d want=3", got); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL bp_leftover got=%0d want=0", exp_q.size()); end
        step();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b want=0", valid_o); end
    endtask

    task automatic test_flush();
        int phantom, n;
        logic [W-1:0] e;
        phantom = 0;
        ready_i = 1'b1;
        for (int t = 0; t < 2; t++) begin randomize_pp(); valid_i = 1'b1; step(); end
        randomize_pp(); valid_i = 1'b1; flush_i = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL flush_pre_valid got=%0b want=1", valid_o); end
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b want=0", valid_o); end
        for (int t = 0; t < 4; t++) begin
            if (valid_o === 1'b1) phantom++;
            step();
        end
        checks++; if (phantom !== 0) begin failures++; $display("FAIL flush_phantom got=%0d want=0", phantom); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b want=1", ready_o); end
        randomize_pp(); e = model_sum(); valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 10) begin step(); n++; end
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL flush_next_timeout got=%0b want=1", valid_o); end
        checks++; if (obs_sum() !== e) begin failures++; $display("FAIL flush_next_sum got=%0h want=%0h", obs_sum(), e); end
        step();
    endtask

    task automatic test_reset_midstream();
        int n;
        ready_i = 1'b0;
        clear_pp();
        ppv[0] = 49'h1_2345_6789_ABCD; ppv[5] = 49'h0_0F0F_0F0F_0F0F;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 10) begin step(); n++; end
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL rstm_pre_valid got=%0b want=1", valid_o); end
        #3 rst_i = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rstm_valid got=%0b want=0", valid_o); end
        checks++; if (sum_o !== '0) begin failures++; $display("FAIL rstm_sum got=%0h want=0", sum_o); end
        checks++; if (carry_o !== '0) begin failures++; $display("FAIL rstm_carry got=%0h want=0", carry_o); end
        checks++; if (flag_o !== 1'b0) begin failures++; $display("FAIL rstm_flag got=%0b want=0", flag_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rstm_ready got=%0b want=1", ready_o); end
        step();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rstm_after got=%0b want=0", valid_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t want=finish before limit", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
